// File: rtl/ntt_sdf_ctrl_if.sv
// Command, buffer-read and stage-chain signals of the SDF NTT job sequencer.
// master = the controller's view, slave = the host / buffers / stage chain.
interface ntt_sdf_ctrl_if #(
  parameter int LOGN = 4
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_intt;
  logic            abort;
  logic            intt;
  logic            in_rd_en;
  logic [LOGN-1:0] in_rd_addr;
  logic            stage_start;
  logic            out_valid;
  logic [LOGN-1:0] out_addr;
  logic            busy;
  logic            done;

  modport master (
    input  cmd_valid, cmd_intt, abort,
    output cmd_ready, intt, in_rd_en, in_rd_addr, stage_start,
           out_valid, out_addr, busy, done
  );

  modport slave (
    output cmd_valid, cmd_intt, abort,
    input  cmd_ready, intt, in_rd_en, in_rd_addr, stage_start,
           out_valid, out_addr, busy, done
  );
endinterface

// File: rtl/ntt_sdf_ctrl.sv
// Job sequencer for a chain of SDF NTT/INTT stages: one command -> N reads, N stage
// starts, N-sample output window. Optional macro NTT_SDF_CTRL_BITREV_EN bit-reverses NTT out_addr.
module ntt_sdf_ctrl #(
  parameter int LOGN     = 4,
  parameter int RD_LAT   = 1,
  parameter int PIPE_LAT = 20
) (
  input logic           clk,
  input logic           rst,
  ntt_sdf_ctrl_if.master bus
);
  localparam int N  = 1 << LOGN;
  localparam int L  = RD_LAT + PIPE_LAT;
  localparam int CW = $clog2(N + L + 1);

  localparam logic [CW-1:0] LAST   = CW'(L + N - 1);
  localparam logic [CW-1:0] N_CYC  = CW'(N);
  localparam logic [CW:0]   N_WIDE = (CW+1)'(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cyc, cyc_nxt;
  logic          intt_q, intt_nxt;
  logic [CW:0]   st_off, out_off;
  logic [LOGN-1:0] nat_addr;

`ifdef NTT_SDF_CTRL_BITREV_EN
  function automatic logic [LOGN-1:0] bit_rev(input logic [LOGN-1:0] x);
    logic [LOGN-1:0] r;
    for (int b = 0; b < LOGN; b++) r[b] = x[LOGN-1-b];
    return r;
  endfunction
`endif

  // Offsets go one bit wider so cycles before a window wrap to a huge value and fail the < N test.
  assign st_off   = {1'b0, cyc} - (CW+1)'(RD_LAT);
  assign out_off  = {1'b0, cyc} - (CW+1)'(L);
  assign nat_addr = out_off[LOGN-1:0];
  assign bus.intt = intt_q;

  // NOTE: reset is synchronous here; only the control state is reset, outputs decode from it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cyc    <= '0;
      intt_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cyc    <= cyc_nxt;
      intt_q <= intt_nxt;
    end
  end

  // NOTE: every output and next-state value gets a default first so no latch is inferred.
  always_comb begin
    state_nxt       = state;
    cyc_nxt         = cyc;
    intt_nxt        = intt_q;
    bus.cmd_ready   = 1'b0;
    bus.in_rd_en    = 1'b0;
    bus.in_rd_addr  = '0;
    bus.stage_start = 1'b0;
    bus.out_valid   = 1'b0;
    bus.out_addr    = '0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;

    unique case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        // abort wins over a simultaneous command
        if (bus.cmd_valid && !bus.abort) begin
          state_nxt = RUN;
          cyc_nxt   = '0;
          intt_nxt  = bus.cmd_intt;
        end
      end

      RUN: begin
        bus.busy        = 1'b1;
        bus.in_rd_en    = (cyc < N_CYC);
        bus.in_rd_addr  = bus.in_rd_en ? cyc[LOGN-1:0] : '0;
        bus.stage_start = (st_off < N_WIDE);
        bus.out_valid   = (out_off < N_WIDE);
        if (bus.out_valid) begin
`ifdef NTT_SDF_CTRL_BITREV_EN
          bus.out_addr = intt_q ? nat_addr : bit_rev(nat_addr);
`else
          bus.out_addr = nat_addr;
`endif
        end
        cyc_nxt = cyc + 1'b1;
        if (bus.abort) begin
          state_nxt = IDLE;
          cyc_nxt   = '0;
        end else if (cyc == LAST) begin
          state_nxt = DONE;
        end
      end

      DONE: begin
        bus.busy  = 1'b1;
        bus.done  = !bus.abort;
        state_nxt = IDLE;
        cyc_nxt   = '0;
      end

      default: begin
        state_nxt = IDLE;
        cyc_nxt   = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_ntt_sdf_ctrl.sv
// Bench for ntt_sdf_ctrl: two instances (default latencies and an overlapping 0/2 case)
// checked every cycle against a job-offset model, plus hand-computed timing literals.
module tb_ntt_sdf_ctrl;
  localparam int LOGN  = 4;
  localparam int N     = 1 << LOGN;
  localparam int RDL_A = 1;
  localparam int PL_A  = 20;
  localparam int RDL_B = 0;
  localparam int PL_B  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_intt  = 1'b0;
  logic abort     = 1'b0;
  bit   chk_en    = 1'b0;

  always #5 clk = ~clk;

  ntt_sdf_ctrl_if #(.LOGN(LOGN)) bus_a ();
  ntt_sdf_ctrl_if #(.LOGN(LOGN)) bus_b ();

  assign bus_a.cmd_valid = cmd_valid;
  assign bus_a.cmd_intt  = cmd_intt;
  assign bus_a.abort     = abort;
  assign bus_b.cmd_valid = cmd_valid;
  assign bus_b.cmd_intt  = cmd_intt;
  assign bus_b.abort     = abort;

  ntt_sdf_ctrl #(.LOGN(LOGN), .RD_LAT(RDL_A), .PIPE_LAT(PL_A)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  ntt_sdf_ctrl #(.LOGN(LOGN), .RD_LAT(RDL_B), .PIPE_LAT(PL_B)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));

  logic            act_ready [2];
  logic            act_intt  [2];
  logic            act_rd_en [2];
  logic [LOGN-1:0] act_rd_addr [2];
  logic            act_ss    [2];
  logic            act_ov    [2];
  logic [LOGN-1:0] act_oa    [2];
  logic            act_busy  [2];
  logic            act_done  [2];

  assign act_ready[0] = bus_a.cmd_ready;   assign act_ready[1] = bus_b.cmd_ready;
  assign act_intt[0]  = bus_a.intt;        assign act_intt[1]  = bus_b.intt;
  assign act_rd_en[0] = bus_a.in_rd_en;    assign act_rd_en[1] = bus_b.in_rd_en;
  assign act_rd_addr[0] = bus_a.in_rd_addr; assign act_rd_addr[1] = bus_b.in_rd_addr;
  assign act_ss[0]    = bus_a.stage_start; assign act_ss[1]    = bus_b.stage_start;
  assign act_ov[0]    = bus_a.out_valid;   assign act_ov[1]    = bus_b.out_valid;
  assign act_oa[0]    = bus_a.out_addr;    assign act_oa[1]    = bus_b.out_addr;
  assign act_busy[0]  = bus_a.busy;        assign act_busy[1]  = bus_b.busy;
  assign act_done[0]  = bus_a.done;        assign act_done[1]  = bus_b.done;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_chk++;
    if (act === 32'(exp)) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int rd_lat(input int d);
    return (d == 0) ? RDL_A : RDL_B;
  endfunction

  function automatic int tot_lat(input int d);
    return (d == 0) ? (RDL_A + PL_A) : (RDL_B + PL_B);
  endfunction

  function automatic int map_addr(input int x, input bit inv);
    int r;
    r = 0;
    if (inv) return x;
`ifdef NTT_SDF_CTRL_BITREV_EN
    for (int b = 0; b < LOGN; b++)
      if (((x >> b) & 1) != 0) r = r | (1 << (LOGN - 1 - b));
    return r;
`else
    return x + r;
`endif
  endfunction

  // Model: a job is just "the cycle index where its cyc=0 falls" plus its mode.
  int cyc_now = 0;
  int run_start [2] = '{0, 0};
  bit active [2]    = '{1'b0, 1'b0};
  bit m_intt [2]    = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int k;
      k = cyc_now - run_start[d];
      if (rst) begin
        active[d] <= 1'b0;
        m_intt[d] <= 1'b0;
      end else if (active[d]) begin
        if (abort || k == tot_lat(d) + N) active[d] <= 1'b0;
      end else if (cmd_valid && !abort) begin
        active[d]    <= 1'b1;
        run_start[d] <= cyc_now + 1;
        m_intt[d]    <= cmd_intt;
      end
    end
    cyc_now <= cyc_now + 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        int k, lt, rl;
        bit e_rd, e_ss, e_ov, e_done;
        int e_ra, e_oa;
        string p;
        p  = (d == 0) ? "a" : "b";
        k  = cyc_now - run_start[d];
        lt = tot_lat(d);
        rl = rd_lat(d);
        e_rd = active[d] && (k < N);
        e_ra = e_rd ? k : 0;
        e_ss = active[d] && (k >= rl) && (k < rl + N);
        e_ov = active[d] && (k >= lt) && (k < lt + N);
        e_oa = e_ov ? map_addr(k - lt, m_intt[d]) : 0;
        e_done = active[d] && (k == lt + N) && !abort;
        check({p, ".cmd_ready"},   32'(act_ready[d]),   int'(!active[d]));
        check({p, ".busy"},        32'(act_busy[d]),    int'(active[d]));
        check({p, ".intt"},        32'(act_intt[d]),    int'(m_intt[d]));
        check({p, ".in_rd_en"},    32'(act_rd_en[d]),   int'(e_rd));
        check({p, ".in_rd_addr"},  32'(act_rd_addr[d]), e_ra);
        check({p, ".stage_start"}, 32'(act_ss[d]),      int'(e_ss));
        check({p, ".out_valid"},   32'(act_ov[d]),      int'(e_ov));
        check({p, ".out_addr"},    32'(act_oa[d]),      e_oa);
        check({p, ".done"},        32'(act_done[d]),    int'(e_done));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a_rd_first, a_rd_cnt, a_ss_first, a_ss_cnt, a_ov_first, a_ov_cnt;
    int a_done_off, a_ready_off, b_ss_first, b_ss_cnt, b_ov_first, b_ov_cnt, b_done_off;
    int addr_q[$];
    int wait_cnt, done_cnt;
    bit intt_drop, got_ready;
    int exp_nat[5];
    int exp_rev[5];

    exp_nat = '{0, 1, 2, 3, 4};
    exp_rev = '{0, 8, 4, 12, 2};

    repeat (3) tick();
    chk_en = 1'b1;
    check("reset.cmd_ready", 32'(bus_a.cmd_ready), 1);
    check("reset.busy",      32'(bus_a.busy), 0);
    rst = 1'b0;
    tick();

    // Job 1: NTT, default-latency instance and overlap instance side by side.
    a_rd_first = -1; a_rd_cnt = 0; a_ss_first = -1; a_ss_cnt = 0;
    a_ov_first = -1; a_ov_cnt = 0; a_done_off = -1; a_ready_off = -1;
    b_ss_first = -1; b_ss_cnt = 0; b_ov_first = -1; b_ov_cnt = 0; b_done_off = -1;
    cmd_intt  = 1'b0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int off = 1; off <= 45; off++) begin
      if (bus_a.in_rd_en) begin if (a_rd_first < 0) a_rd_first = off; a_rd_cnt++; end
      if (bus_a.stage_start) begin if (a_ss_first < 0) a_ss_first = off; a_ss_cnt++; end
      if (bus_a.out_valid) begin
        if (a_ov_first < 0) a_ov_first = off;
        a_ov_cnt++;
        if (addr_q.size() < 5) addr_q.push_back(int'(bus_a.out_addr));
      end
      if (bus_a.done && a_done_off < 0) a_done_off = off;
      if (bus_a.cmd_ready && a_ready_off < 0) a_ready_off = off;
      if (bus_b.stage_start) begin if (b_ss_first < 0) b_ss_first = off; b_ss_cnt++; end
      if (bus_b.out_valid) begin if (b_ov_first < 0) b_ov_first = off; b_ov_cnt++; end
      if (bus_b.done && b_done_off < 0) b_done_off = off;
      tick();
    end
    check("j1.rd_first", 32'(a_rd_first), 1);
    check("j1.rd_count", 32'(a_rd_cnt), 16);
    check("j1.ss_first", 32'(a_ss_first), 2);
    check("j1.ss_count", 32'(a_ss_cnt), 16);
    check("j1.ov_first", 32'(a_ov_first), 22);
    check("j1.ov_count", 32'(a_ov_cnt), 16);
    check("j1.done_off", 32'(a_done_off), 38);
    check("j1.ready_off", 32'(a_ready_off), 39);
    check("ovl.ss_first", 32'(b_ss_first), 1);
    check("ovl.ss_count", 32'(b_ss_cnt), 16);
    check("ovl.ov_first", 32'(b_ov_first), 3);
    check("ovl.ov_count", 32'(b_ov_cnt), 16);
    check("ovl.done_off", 32'(b_done_off), 19);
    check("j1.addr_count", 32'(addr_q.size()), 5);
    for (int i = 0; i < 5 && i < addr_q.size(); i++) begin
`ifdef NTT_SDF_CTRL_BITREV_EN
      check("j1.ntt_addr", 32'(addr_q[i]), exp_rev[i]);
`else
      check("j1.ntt_addr", 32'(addr_q[i]), exp_nat[i]);
`endif
    end

    // Job 2: INTT with cmd_valid held and cmd_intt toggling; job 3 chains at ready.
    addr_q.delete();
    intt_drop = 1'b0;
    got_ready = 1'b0;
    wait_cnt  = 0;
    cmd_intt  = 1'b1;
    cmd_valid = 1'b1;
    tick();
    for (int i = 1; i <= 100; i++) begin
      if (bus_a.cmd_ready) begin got_ready = 1'b1; break; end
      if (bus_a.intt !== 1'b1) intt_drop = 1'b1;
      if (bus_a.out_valid && addr_q.size() < 4) addr_q.push_back(int'(bus_a.out_addr));
      cmd_intt = (i < 30) ? ~cmd_intt : 1'b0;
      wait_cnt++;
      tick();
    end
    check("j2.ready_seen", 32'(got_ready), 1);
    check("j2.ready_ticks", 32'(wait_cnt), 38);
    check("j2.intt_stable", 32'(intt_drop), 0);
    check("j2.intt_idle", 32'(bus_a.intt), 1);
    check("j2.addr_count", 32'(addr_q.size()), 4);
    for (int i = 0; i < 4 && i < addr_q.size(); i++)
      check("j2.intt_addr", 32'(addr_q[i]), exp_nat[i]);
    tick();
    cmd_valid = 1'b0;
    check("j3.first_rd", 32'(bus_a.in_rd_en), 1);
    check("j3.first_addr", 32'(bus_a.in_rd_addr), 0);
    check("j3.intt", 32'(bus_a.intt), 0);
    repeat (45) tick();
    check("j3.idle", 32'(bus_a.cmd_ready), 1);

    // Job 4: abort at t0+10, then abort together with a command in IDLE.
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort.busy", 32'(bus_a.busy), 0);
    check("abort.rd_en", 32'(bus_a.in_rd_en), 0);
    check("abort.stage_start", 32'(bus_a.stage_start), 0);
    check("abort.ready", 32'(bus_a.cmd_ready), 1);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus_a.done) done_cnt++;
      tick();
    end
    check("abort.no_done", 32'(done_cnt), 0);
    cmd_valid = 1'b1;
    abort     = 1'b1;
    tick();
    cmd_valid = 1'b0;
    abort     = 1'b0;
    check("abort_idle.busy_a", 32'(bus_a.busy), 0);
    check("abort_idle.busy_b", 32'(bus_b.busy), 0);
    repeat (2) tick();

    // Job 5: INTT, reset at t0+25.
    cmd_intt  = 1'b1;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (24) tick();
    check("rst.pre_busy", 32'(bus_a.busy), 1);
    check("rst.pre_intt", 32'(bus_a.intt), 1);
    rst = 1'b1;
    tick();
    check("rst.intt", 32'(bus_a.intt), 0);
    check("rst.ready", 32'(bus_a.cmd_ready), 1);
    check("rst.busy", 32'(bus_a.busy), 0);
    check("rst.out_valid", 32'(bus_a.out_valid), 0);
    rst = 1'b0;
    repeat (3) tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ntt_sdf_ctrl.md
Name: ntt_sdf_ctrl

Overview:
Job sequencer for a chain of SDF NTT/INTT stages. It accepts one transform command at a time and streams N coefficient reads out of the input buffer. It drives the first stage's per-sample start strobe and the pipeline-wide intt mode, then times the N-sample output window after the chain latency and signals job completion. It sits between the host command interface / coefficient buffers and the stage chain.

Parameters:
- LOGN, 4, log2 of transform size N.
- RD_LAT, 1, input buffer read latency in cycles (>=0).
- PIPE_LAT, 20, total cycles from first stage_start to first valid sample at the chain output (>=1).

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset.
- cmd_valid, in, 1, command request.
- cmd_ready, out, 1, controller can accept a command.
- cmd_intt, in, 1, mode for the command: 0 = NTT, 1 = INTT.
- abort, in, 1, cancel the current job.
- intt, out, 1, mode to all stages; latched for the whole job.
- in_rd_en, out, 1, input buffer read strobe.
- in_rd_addr, out, LOGN, input buffer read address.
- stage_start, out, 1, per-sample valid into stage 0.
- out_valid, out, 1, chain output sample valid.
- out_addr, out, LOGN, write address for the output sample.
- busy, out, 1, job in progress.
- done, out, 1, one-cycle job-complete pulse.

Behaviour:
- Reset is synchronous, active-high, on clk. All outputs are 0 during and after reset except cmd_ready, which is 1. State = IDLE, cycle counter = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready = 1.
  - A handshake (cmd_valid & cmd_ready) latches cmd_intt into intt, clears the counter cyc and enters RUN.
- RUN:
  - Counter width is clog2(N+RD_LAT+PIPE_LAT+1). cyc = 0 in the first RUN cycle and increments once per cycle.
  - in_rd_en = 1 for cyc 0..N-1, with in_rd_addr = cyc[LOGN-1:0]; in_rd_addr = 0 otherwise.
  - stage_start = 1 for cyc RD_LAT..RD_LAT+N-1, i.e. exactly N consecutive cycles.
  - out_valid = 1 for cyc L..L+N-1, where L = RD_LAT+PIPE_LAT.
  - out_addr = cyc-L (LOGN bits) while out_valid = 1; out_addr = 0 otherwise.
  - Input and output windows may overlap when L < N; both are generated independently from cyc.
  - At cyc = L+N-1, go to DONE.
- DONE: done = 1 for one cycle, then go to IDLE.
- busy = 1 in RUN and DONE. cmd_ready = 0 in RUN and DONE.
- intt holds its latched value until the next handshake, including while in IDLE.
- cmd_valid outside IDLE is ignored; it is not queued.
- abort in RUN or DONE:
  - Next cycle: IDLE, and in_rd_en, stage_start, out_valid, busy and done are all 0.
  - done is not pulsed.
  - abort in IDLE has no effect.
- abort and cmd_valid in the same IDLE cycle: abort has priority and the command is not accepted.
- rst mid-job has the same effect as abort, plus intt is cleared to 0.
- No backpressure: the stage chain cannot stall, so output timing is fixed by parameters.

Optional Feature:
- Macro: NTT_SDF_CTRL_BITREV_EN.
- Defined: when the latched intt = 0, out_addr is the LOGN-bit bit-reversal of (cyc-L), so NTT output is written in natural order. When intt = 1, out_addr is natural.
- Undefined: out_addr is always natural (cyc-L), regardless of mode.

Test Plan:
- Defaults (N=16, RD_LAT=1, PIPE_LAT=20); handshake at cycle t0 with cmd_intt=0 -> the following, and no extra strobes:
  - in_rd_en at t0+1..t0+16 with addresses 0..15.
  - stage_start at t0+2..t0+17.
  - out_valid at t0+22..t0+37 with out_addr 0..15.
  - done at t0+38.
  - cmd_ready = 1 again at t0+39.
- cmd_intt=1 job, then toggle cmd_intt while busy -> intt = 1 for the whole job and stays 1 in IDLE afterwards. A second job with cmd_intt=0 clears intt at its handshake.
- cmd_valid held high during a job -> no second latch while busy. A new job starts exactly at the cycle cmd_ready returns (t0+39), with its first in_rd_en at t0+40.
- abort at t0+10 -> at t0+11 all strobes are 0 and busy = 0; done never pulses. abort together with cmd_valid in IDLE -> no job starts.
- rst asserted at t0+25 -> outputs are at reset values next cycle, intt = 0, cmd_ready = 1.
- With NTT_SDF_CTRL_BITREV_EN, N=16, intt=0 -> out_addr sequence starts 0, 8, 4, 12, 2. With intt=1 -> 0, 1, 2, 3. With the macro undefined -> natural order in both modes.
- PIPE_LAT=2, RD_LAT=0 (overlap case) -> stage_start at cyc 0..15 and out_valid at cyc 2..17 overlap correctly; done at cyc 18.
